// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word-addressed RAM. The read and write paths are
// independent FSMs, and each one holds at most one outstanding burst.
module axi_slave_mem #(
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_DATA_WD = 32,
  parameter int AXI_ADDR_WD = 32,
  parameter int AXI_STRB_WD = 4,
  parameter int MEM_DEPTH   = 1024
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [AXI_ADDR_WD-1:0] S_AXI_AWADDR,
  input  logic [AXI_ID_WD-1:0]   S_AXI_AWID,
  input  logic [1:0]             S_AXI_AWBURST,
  input  logic [2:0]             S_AXI_AWSIZE,
  input  logic [7:0]             S_AXI_AWLEN,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [AXI_DATA_WD-1:0] S_AXI_WDATA,
  input  logic [AXI_STRB_WD-1:0] S_AXI_WSTRB,
  input  logic                   S_AXI_WLAST,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [AXI_ID_WD-1:0]   S_AXI_BID,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [AXI_ADDR_WD-1:0] S_AXI_ARADDR,
  input  logic [AXI_ID_WD-1:0]   S_AXI_ARID,
  input  logic [1:0]             S_AXI_ARBURST,
  input  logic [2:0]             S_AXI_ARSIZE,
  input  logic [7:0]             S_AXI_ARLEN,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [AXI_DATA_WD-1:0] S_AXI_RDATA,
  output logic [AXI_ID_WD-1:0]   S_AXI_RID,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RLAST,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY
);

  localparam int STRB_LG = $clog2(AXI_STRB_WD);
  localparam int IDX_WD  = $clog2(MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [AXI_DATA_WD-1:0] mem [MEM_DEPTH];

  function automatic logic [AXI_ADDR_WD-1:0] next_addr(
    input logic [AXI_ADDR_WD-1:0] addr,
    input logic [1:0]             burst,
    input logic [2:0]             size,
    input logic [7:0]             len
  );
    logic [AXI_ADDR_WD-1:0] one, inc, bound;
    one   = AXI_ADDR_WD'(1);
    inc   = one << size;
    bound = (AXI_ADDR_WD'(len) + one) << size;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~(bound - one)) | ((addr + inc) & (bound - one));
      default: next_addr = addr + inc;
    endcase
  endfunction

  function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
    bad_burst = (burst == 2'b11) ||
                (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [IDX_WD-1:0] word_idx(input logic [AXI_ADDR_WD-1:0] addr);
    word_idx = addr[STRB_LG +: IDX_WD];
  endfunction

  function automatic logic out_of_range(input logic [AXI_ADDR_WD-1:0] addr);
    out_of_range = |addr[AXI_ADDR_WD-1:STRB_LG+IDX_WD];
  endfunction

  logic [1:0]             w_state;
  logic [AXI_ADDR_WD-1:0] w_addr, w_next;
  logic [AXI_ID_WD-1:0]   w_id;
  logic [1:0]             w_burst;
  logic [2:0]             w_size;
  logic [7:0]             w_len, w_cnt;
  logic                   w_slverr, w_decerr;

  assign w_next = next_addr(w_addr, w_burst, w_size, w_len);

  // Illegal burst types are latched as INCR so the address walk stays well defined.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state  <= W_IDLE;
      w_addr   <= '0;
      w_id     <= '0;
      w_burst  <= '0;
      w_size   <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_slverr <= 1'b0;
      w_decerr <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (S_AXI_AWVALID) begin
          w_addr   <= S_AXI_AWADDR;
          w_id     <= S_AXI_AWID;
          w_burst  <= bad_burst(S_AXI_AWBURST, S_AXI_AWLEN) ? 2'b01 : S_AXI_AWBURST;
          w_size   <= S_AXI_AWSIZE;
          w_len    <= S_AXI_AWLEN;
          w_cnt    <= '0;
          w_slverr <= bad_burst(S_AXI_AWBURST, S_AXI_AWLEN) || (S_AXI_AWSIZE > 3'(STRB_LG));
          w_decerr <= out_of_range(S_AXI_AWADDR);
          w_state  <= W_DATA;
        end
        W_DATA: if (S_AXI_WVALID) begin
          w_addr <= w_next;
          w_cnt  <= w_cnt + 8'd1;
          if (S_AXI_WLAST != (w_cnt == w_len)) w_slverr <= 1'b1;
          if (w_cnt == w_len) w_state <= W_RESP;
        end
        W_RESP: if (S_AXI_BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_state == W_DATA && S_AXI_WVALID && !w_decerr) begin
      for (int b = 0; b < AXI_STRB_WD; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = (w_state == W_IDLE);
  assign S_AXI_WREADY  = (w_state == W_DATA);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BID     = w_id;
  assign S_AXI_BRESP   = w_decerr ? 2'b11 : (w_slverr ? 2'b10 : 2'b00);

  logic [0:0]             r_state;
  logic [AXI_ADDR_WD-1:0] r_addr, r_next;
  logic [1:0]             r_burst;
  logic [2:0]             r_size;
  logic [7:0]             r_len, r_cnt;
  logic                   r_decerr, r_last;
  logic [AXI_ID_WD-1:0]   r_id;
  logic [1:0]             r_resp;
  logic [AXI_DATA_WD-1:0] r_data;

  assign r_next = next_addr(r_addr, r_burst, r_size, r_len);

  // Next beat's data is fetched on the accepting handshake so RVALID never bubbles.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= R_IDLE;
      r_addr   <= '0;
      r_burst  <= '0;
      r_size   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_decerr <= 1'b0;
      r_last   <= 1'b0;
      r_id     <= '0;
      r_resp   <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (S_AXI_ARVALID) begin
          r_addr   <= S_AXI_ARADDR;
          r_burst  <= bad_burst(S_AXI_ARBURST, S_AXI_ARLEN) ? 2'b01 : S_AXI_ARBURST;
          r_size   <= S_AXI_ARSIZE;
          r_len    <= S_AXI_ARLEN;
          r_cnt    <= '0;
          r_id     <= S_AXI_ARID;
          r_decerr <= out_of_range(S_AXI_ARADDR);
          r_resp   <= out_of_range(S_AXI_ARADDR) ? 2'b11 :
                      ((bad_burst(S_AXI_ARBURST, S_AXI_ARLEN) || (S_AXI_ARSIZE > 3'(STRB_LG)))
                       ? 2'b10 : 2'b00);
          r_data   <= out_of_range(S_AXI_ARADDR) ? '0 : mem[word_idx(S_AXI_ARADDR)];
          r_last   <= (S_AXI_ARLEN == 8'd0);
          r_state  <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) begin
          if (r_last) begin
            r_last  <= 1'b0;
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_next;
            r_cnt  <= r_cnt + 8'd1;
            r_last <= ((r_cnt + 8'd1) == r_len);
            r_data <= r_decerr ? '0 : mem[word_idx(r_next)];
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_ARREADY = (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RID     = r_id;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RLAST   = r_last;

endmodule
